// File: rtl/pulse_ext_pkg.sv
// Shared types and helpers for the multi-channel pulse stretcher.
package pulse_ext_pkg;

  // Per-channel pulse state
  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  // Default counter/length width and the widest width any channel may use
  localparam int DEFAULT_CNT_W = 8;
  localparam int MAX_CNT_W     = 16;

  // A programmed length of zero still produces a one-cycle pulse
  function automatic logic [MAX_CNT_W-1:0] eff_len(input logic [MAX_CNT_W-1:0] len);
    return (len == '0) ? MAX_CNT_W'(1) : len;
  endfunction

endpackage

// File: rtl/pulse_stretch_channel.sv
// One stretcher channel: edge history, IDLE/ACTIVE FSM, down-counter,
// registered stretched output and expiry strobe.
module pulse_stretch_channel
  import pulse_ext_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal,
  input  logic [CNT_W-1:0] length,
  input  logic             edge_mode,
  input  logic             retrigger,
  output logic             extendedSignal,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ext_q, ext_d;
  logic             done_q, done_d;
  logic             prev_q;

  logic                 trig;
  logic [MAX_CNT_W-1:0] lenWide;
  logic [MAX_CNT_W-1:0] leffWide;
  logic [CNT_W-1:0]     loadVal;

  assign lenWide  = MAX_CNT_W'(length);
  assign leffWide = eff_len(lenWide);
  assign loadVal  = CNT_W'(leffWide - MAX_CNT_W'(1));

  assign trig = edge_mode ? (signal & ~prev_q) : signal;

  // State, counter, outputs and edge history; reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ext_q   <= 1'b0;
      done_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
      done_q  <= done_d;
      prev_q  <= signal;
    end
  end

  // Next state: load on trigger, reload on retrigger, else count down to expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ext_d   = ext_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = ACTIVE;
          ext_d   = 1'b1;
          cnt_d   = loadVal;
        end
      end
      ACTIVE: begin
        if (retrigger && trig) begin
          cnt_d = loadVal;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          ext_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ext_d   = 1'b0;
      end
    endcase
  end

  assign extendedSignal = ext_q;
  assign done           = done_q;

endmodule

// File: rtl/pulse_stretcher_multi.sv
// N independent pulse stretcher channels sharing length and mode controls,
// with a combined busy flag.
module pulse_stretcher_multi
  import pulse_ext_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] signal,
  input  logic [CNT_W-1:0]    length,
  input  logic                edge_mode,
  input  logic                retrigger,
  output logic [CHANNELS-1:0] extendedSignal,
  output logic [CHANNELS-1:0] done,
  output logic                busy
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_stretch_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .signal        (signal[i]),
      .length        (length),
      .edge_mode     (edge_mode),
      .retrigger     (retrigger),
      .extendedSignal(extendedSignal[i]),
      .done          (done[i])
    );
  end

  assign busy = |extendedSignal;

endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// Self-checking bench for pulse_stretcher_multi: table-driven single-channel
// scenarios plus hand-written reset and all-channel sequences, with a
// scoreboard of expected pulse statistics.
module tb_pulse_stretcher_multi;

  localparam int CH = 4;
  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic [CH-1:0] signal;
  logic [CW-1:0] length;
  logic          edge_mode;
  logic          retrigger;
  logic [CH-1:0] extendedSignal;
  logic [CH-1:0] done;
  logic          busy;

  pulse_stretcher_multi #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .signal        (signal),
    .length        (length),
    .edge_mode     (edge_mode),
    .retrigger     (retrigger),
    .extendedSignal(extendedSignal),
    .done          (done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    ch;
    int    len;
    bit    edgeM;
    bit    retrig;
    int    hold;
    int    secondAt;
    int    newLenAt;
    int    newLen;
    int    expHigh;
    int    expDone;
    int    expPulses;
  } vec_t;

  typedef struct {
    string name;
    int    ch;
    int    expHigh;
    int    expDone;
    int    expPulses;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[$];

  int checks = 0;
  int passed = 0;

  int highCnt[CH];
  int doneCnt[CH];
  int pulseCnt[CH];
  int busyHigh;
  int busyErr;
  int alignErr;
  logic [CH-1:0] prevExt;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic resetCounters();
    for (int i = 0; i < CH; i++) begin
      highCnt[i]  = 0;
      doneCnt[i]  = 0;
      pulseCnt[i] = 0;
    end
    busyHigh = 0;
    busyErr  = 0;
    alignErr = 0;
  endtask

  // Called #1 after a rising edge: accumulate pulse statistics for all channels
  task automatic sampleCycle();
    for (int i = 0; i < CH; i++) begin
      if (extendedSignal[i]) highCnt[i]++;
      if (extendedSignal[i] && !prevExt[i]) pulseCnt[i]++;
      if (done[i]) begin
        doneCnt[i]++;
        if (extendedSignal[i] || !prevExt[i]) alignErr++;
      end
    end
    if (busy) busyHigh++;
    if (busy !== (|extendedSignal)) busyErr++;
    prevExt = extendedSignal;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    sampleCycle();
  endtask

  task automatic drainScoreboard();
    exp_t e;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({e.name, " high"},   highCnt[e.ch],  e.expHigh);
      checkOutput({e.name, " done"},   doneCnt[e.ch],  e.expDone);
      checkOutput({e.name, " pulses"}, pulseCnt[e.ch], e.expPulses);
    end
    checkOutput("done aligned with fall", alignErr, 0);
    checkOutput("busy equals OR", busyErr, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int leff;
    int win;
    logic [CH-1:0] s;
    exp_t e;
    leff = (v.len == 0) ? 1 : v.len;
    win  = v.hold + ((v.secondAt > 0) ? v.secondAt : 0) + leff + 6;
    resetCounters();
    length    = CW'(v.len);
    edge_mode = v.edgeM;
    retrigger = v.retrig;
    e.name = v.name; e.ch = v.ch;
    e.expHigh = v.expHigh; e.expDone = v.expDone; e.expPulses = v.expPulses;
    sbQ.push_back(e);
    for (int k = 0; k < win; k++) begin
      s = '0;
      if (k < v.hold || k == v.secondAt) s[v.ch] = 1'b1;
      if (k == v.newLenAt) length = CW'(v.newLen);
      signal = s;
      stepCycle();
    end
    signal = '0;
    for (int i = 0; i < CH; i++)
      if (i != v.ch) checkOutput({v.name, " other ch quiet"}, highCnt[i], 0);
    drainScoreboard();
  endtask

  function automatic vec_t mk(input string n, input int ch, input int len, input bit em,
                              input bit rt, input int hold, input int sec, input int nla,
                              input int nl, input int eh, input int ed, input int ep);
    vec_t v;
    v.name = n; v.ch = ch; v.len = len; v.edgeM = em; v.retrig = rt;
    v.hold = hold; v.secondAt = sec; v.newLenAt = nla; v.newLen = nl;
    v.expHigh = eh; v.expDone = ed; v.expPulses = ep;
    return v;
  endfunction

  initial begin
    exp_t e;
    reset     = 1'b0;
    signal    = '0;
    length    = '0;
    edge_mode = 1'b0;
    retrigger = 1'b0;
    prevExt   = '0;

    vecs.push_back(mk("single L16",      0, 16,  0, 0, 1,  -1, -1, 0, 16,  1, 1));
    vecs.push_back(mk("retrig on L5",    0, 5,   0, 1, 1,   3, -1, 0, 8,   1, 1));
    vecs.push_back(mk("retrig off L5",   0, 5,   0, 0, 1,   3, -1, 0, 5,   1, 1));
    vecs.push_back(mk("level hold L3",   1, 3,   0, 0, 12, -1, -1, 0, 9,   3, 3));
    vecs.push_back(mk("edge hold L3",    1, 3,   1, 0, 12, -1, -1, 0, 3,   1, 1));
    vecs.push_back(mk("length zero",     2, 0,   0, 0, 1,  -1, -1, 0, 1,   1, 1));
    vecs.push_back(mk("length 255",      3, 255, 0, 0, 1,  -1, -1, 0, 255, 1, 1));
    vecs.push_back(mk("len change 4to9", 1, 4,   0, 0, 1,  -1,  2, 9, 4,   1, 1));
    vecs.push_back(mk("edge retrig L4",  2, 4,   1, 1, 1,   2, -1, 0, 6,   1, 1));

    // Reset state while held and just after release
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ext",  int'(extendedSignal), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset busy", int'(busy), 0);
    reset = 1'b1;
    stepCycle();
    checkOutput("post-reset ext", int'(extendedSignal), 0);

    foreach (vecs[n]) applyStimulus(vecs[n]);

    // Reset mid-pulse: outputs clear immediately, no expiry strobe
    resetCounters();
    length = CW'(20); edge_mode = 1'b0; retrigger = 1'b0;
    signal = 4'b0001;
    stepCycle();
    signal = '0;
    repeat (6) stepCycle();
    checkOutput("pre-reset high", highCnt[0], 7);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset ext",  int'(extendedSignal), 0);
    checkOutput("async reset done", int'(done), 0);
    checkOutput("async reset busy", int'(busy), 0);
    signal = 4'b0001; edge_mode = 1'b1;
    repeat (3) stepCycle();
    checkOutput("no done during reset", doneCnt[0], 0);
    checkOutput("held in reset high", highCnt[0], 7);
    reset = 1'b1;
    resetCounters();
    e.name = "after reset edge"; e.ch = 0; e.expHigh = 20; e.expDone = 1; e.expPulses = 1;
    sbQ.push_back(e);
    repeat (40) stepCycle();
    signal = '0;
    repeat (2) stepCycle();
    drainScoreboard();

    // All channels together, channel 2 retriggered on its fifth high cycle
    resetCounters();
    length = CW'(6); edge_mode = 1'b0; retrigger = 1'b1;
    for (int i = 0; i < CH; i++) begin
      e.name = $sformatf("all ch%0d", i); e.ch = i;
      e.expHigh = (i == 2) ? 10 : 6; e.expDone = 1; e.expPulses = 1;
      sbQ.push_back(e);
    end
    for (int k = 0; k < 16; k++) begin
      signal = (k == 0) ? 4'b1111 : ((k == 4) ? 4'b0100 : 4'b0000);
      stepCycle();
    end
    signal = '0;
    checkOutput("all busy high", busyHigh, 10);
    drainScoreboard();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
